// File: rtl/bit_serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package bit_serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_addsub_if.sv
// Request/result bundle between an operand source and the bit-serial adder/subtractor.
interface bit_serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/bit_serial_addsub_full_adder.sv
// Single-bit full adder cell shared by every bit position of the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_serial_addsub.sv
// WIDTH-bit adder/subtractor processing one bit per clock, LSB first, through one full adder.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one bit per clock through the full adder
// DONE  | result committed, done pulse; start here chains the next operation
module bit_serial_addsub
    import bit_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_serial_addsub_if.slave bus
);
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (cy_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // The partial sum keeps only the WIDTH-1 finished bits; the final bit joins it at commit.
    assign s_next = {fa_s, s_sh_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                    s_sh_d  = '0;
                    cy_d    = bus.mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                s_sh_d = s_next[WIDTH-1:1];
                cy_d   = fa_cout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = s_next;
                    carry_d = fa_cout;
                    ovf_d   = cy_q ^ fa_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/bit_serial_addsub.md
# bit_serial_addsub

Parametrised, bit-serial adder/subtractor: successor to the 4-bit ripple-carry adder, generalised to WIDTH bits with an add/subtract mode and signed-overflow flag. Processes one bit per clock through a single full-adder cell, LSB first, under a start/busy/done handshake. Sits behind the lab datapath's operand registers wherever area matters more than latency.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- mode  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse: result valid and just committed.
- sum  out  WIDTH  result; held until the next commit.
- carry  out  1  add: carry out of MSB; sub: NOT borrow (1 when a >= b unsigned).
- overflow  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> load A shift reg = a, B shift reg = mode ? ~b : b, carry reg = mode, bit counter = 0; go RUN. start=0 -> stay.
- RUN: each cycle the full adder takes A[0], B[0], carry reg; sum bit shifts into the MSB of the sum shift reg; A and B shift right; carry reg <= carry-out; counter++.
- When processing bit WIDTH-1: capture carry-in of that bit (for overflow); commit sum shift reg (with the final bit), carry, overflow to output regs; go DONE.
- DONE: done=1 for exactly one cycle. start=1 -> load as in IDLE, go RUN (back-to-back). Otherwise -> IDLE.
- start in RUN ignored. a/b/mode changes after the sampling edge have no effect.
- Outputs sum/carry/overflow change only at commit; they hold the previous result throughout RUN.
- Arithmetic is modulo 2^WIDTH; counter width $clog2(WIDTH).

## Timing
- Reset (async assert, any state including mid-RUN): state IDLE, busy 0, done 0, sum 0, carry 0, overflow 0, shift regs/counter 0. Deassertion is synchronised by the system; the first start is accepted at the first edge with rst_n high.
- start sampled at edge k -> busy high from edge k to edge k+WIDTH; bits processed at edges k+1..k+WIDTH; outputs committed at edge k+WIDTH; done high between edges k+WIDTH and k+WIDTH+1.
- Latency WIDTH edges; throughput one operation per WIDTH+1 cycles with back-to-back start.
- busy and done are never high together.

## Structure
- Shared package: state enum (IDLE/RUN/DONE), MODE_ADD=0 / MODE_SUB=1 constants.
- Sub-module: full_adder (a, b, cin -> s, cout), one instance; the rest is the FSM plus shift registers in the top.

## Test plan
- WIDTH=4, add 7+9 -> sum 0, carry 1, overflow 0; busy high 4 cycles, done 1 cycle, done edge exactly 4 edges after start.
- WIDTH=4, add 5+4 -> sum 9, carry 0, overflow 1; then sub 3-5 -> sum 14, carry 0, overflow 0; sub 5-3 -> sum 2, carry 1.
- WIDTH=4, sub 8-1 -> sum 7, carry 1, overflow 1; sum holds 2 (previous result) throughout RUN until commit.
- start held during RUN and a/b toggled mid-run -> ignored, result matches originally sampled operands; start in DONE -> next op begins with no IDLE cycle.
- Assert rst_n low after 2 bits of a run -> all outputs 0 immediately (before next edge), state IDLE; subsequent add 1+1 -> sum 2.
- WIDTH=8, add 200+100 -> sum 44, carry 1, overflow 0 (signed -56+100); done 8 edges after start.
